// File: rtl/aes_seq_pkg.sv
// Shared definitions for the AES batch sequencer: FSM states and text width.
package aes_seq_pkg;

    localparam int STATE_W       = 3;
    localparam int AES128_TEXT_W = 128;

    typedef enum logic [STATE_W-1:0] {
        IDLE      = 3'd0,
        LOAD      = 3'd1,
        WAIT_BUSY = 3'd2,
        RUN       = 3'd3,
        CAPTURE   = 3'd4
    } seq_state_e;

endpackage

// File: rtl/aes_batch_sequencer_if.sv
// Load/busy handshake between the batch sequencer (master) and the AES core (slave).
interface aes_batch_sequencer_if
    import aes_seq_pkg::*;
#(
    parameter int pTEXT_WIDTH = AES128_TEXT_W
);

    logic                   O_aes_load;
    logic [pTEXT_WIDTH-1:0] O_aes_pt;
    logic                   I_aes_busy;
    logic [pTEXT_WIDTH-1:0] I_aes_ct;

    modport master (
        output O_aes_load,
        output O_aes_pt,
        input  I_aes_busy,
        input  I_aes_ct
    );

    modport slave (
        input  O_aes_load,
        input  O_aes_pt,
        output I_aes_busy,
        output I_aes_ct
    );

endinterface

// File: rtl/aes_seq_timeout.sv
// Saturating up-counter; expire flags the enabled cycle on which the count would reach pLIMIT.
module aes_seq_timeout #(
    parameter int pLIMIT = 8
) (
    input  logic crypto_clk,
    input  logic resetn,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(pLIMIT + 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && (cnt != CW'(pLIMIT))) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign expire = en && (cnt == CW'(pLIMIT - 1));

endmodule

// File: rtl/aes_batch_sequencer.sv
// Runs the AES core through a batch of back-to-back encryptions from one start pulse,
// with optional ciphertext chaining, a scope trigger window, busy timeout and abort.
module aes_batch_sequencer
    import aes_seq_pkg::*;
#(
    parameter int pCNT_WIDTH  = 16,
    parameter int pTIMEOUT    = 8,
    parameter int pTEXT_WIDTH = AES128_TEXT_W
) (
    input  logic                   crypto_clk,
    input  logic                   resetn,
    input  logic                   I_start,
    input  logic                   I_abort,
    input  logic [pCNT_WIDTH-1:0]  I_batch_count,
    input  logic                   I_chain,
    input  logic                   I_trig_first_only,
    input  logic [pTEXT_WIDTH-1:0] I_textin,
    aes_batch_sequencer_if.master  core,
    output logic [pTEXT_WIDTH-1:0] O_cipherout,
    output logic [pCNT_WIDTH-1:0]  O_remaining,
    output logic                   O_busy,
    output logic                   O_done,
    output logic                   O_error,
    output logic                   O_trigger
);

    seq_state_e             state;
    logic [pTEXT_WIDTH-1:0] pt_q;
    logic                   load_q;
    logic                   chain_q;
    logic                   first_only_q;
    logic                   first_enc_q;
    logic                   expire;

    // Remaining count never wraps below zero, even for an all-ones batch.
    function automatic logic [pCNT_WIDTH-1:0] sat_dec(input logic [pCNT_WIDTH-1:0] v);
        return (v == '0) ? v : v - 1'b1;
    endfunction

    aes_seq_timeout #(
        .pLIMIT (pTIMEOUT)
    ) u_timeout (
        .crypto_clk (crypto_clk),
        .resetn     (resetn),
        .clr        (state == LOAD),
        .en         (state == WAIT_BUSY),
        .expire     (expire)
    );

    assign core.O_aes_load = load_q;
    assign core.O_aes_pt   = pt_q;

    always_ff @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            state        <= IDLE;
            pt_q         <= '0;
            load_q       <= 1'b0;
            chain_q      <= 1'b0;
            first_only_q <= 1'b0;
            first_enc_q  <= 1'b0;
            O_cipherout  <= '0;
            O_remaining  <= '0;
            O_busy       <= 1'b0;
            O_done       <= 1'b0;
            O_error      <= 1'b0;
            O_trigger    <= 1'b0;
        end else begin
            load_q    <= 1'b0;
            // Trigger follows the state one cycle late: high over LOAD..RUN of qualifying runs.
            O_trigger <= ((state == LOAD) || (state == WAIT_BUSY) || (state == RUN)) &&
                         (!first_only_q || first_enc_q);

            if (I_abort) begin
                // Abort also swallows a coincident start; the core is left to finish alone.
                state   <= IDLE;
                O_busy  <= 1'b0;
                if (state != IDLE) begin
                    O_done  <= 1'b0;
                    O_error <= 1'b0;
                end
            end else begin
                case (state)
                    IDLE: begin
                        if (I_start) begin
                            O_done       <= (I_batch_count == '0);
                            O_error      <= 1'b0;
                            O_remaining  <= I_batch_count;
                            pt_q         <= I_textin;
                            chain_q      <= I_chain;
                            first_only_q <= I_trig_first_only;
                            first_enc_q  <= 1'b1;
                            if (I_batch_count != '0) begin
                                state  <= LOAD;
                                load_q <= 1'b1;
                                O_busy <= 1'b1;
                            end
                        end
                    end
                    LOAD: begin
                        state <= WAIT_BUSY;
                    end
                    WAIT_BUSY: begin
                        if (core.I_aes_busy) begin
                            state <= RUN;
                        end else if (expire) begin
                            state   <= IDLE;
                            O_busy  <= 1'b0;
                            O_error <= 1'b1;
                            O_done  <= 1'b1;
                        end
                    end
                    RUN: begin
                        if (!core.I_aes_busy) begin
                            state <= CAPTURE;
                        end
                    end
                    CAPTURE: begin
                        O_cipherout <= core.I_aes_ct;
                        O_remaining <= sat_dec(O_remaining);
                        first_enc_q <= 1'b0;
                        if (chain_q) begin
                            pt_q <= core.I_aes_ct;
                        end
                        if (sat_dec(O_remaining) == '0) begin
                            state  <= IDLE;
                            O_busy <= 1'b0;
                            O_done <= 1'b1;
                        end else begin
                            state  <= LOAD;
                            load_q <= 1'b1;
                        end
                    end
                    default: begin
                        state  <= IDLE;
                        O_busy <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aes_batch_sequencer.sv
// Bench for aes_batch_sequencer: stub AES core, batch-level model and directed batches.
module tb_aes_batch_sequencer;
    import aes_seq_pkg::*;

    localparam int CW     = 16;
    localparam int TW     = 128;
    localparam int TO     = 8;
    localparam int RUNLEN = 10;

    localparam logic [TW-1:0] PT0 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [TW-1:0] CT0 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [TW-1:0] PT1 = 128'h0123456789abcdeffedcba9876543210;

    logic          crypto_clk = 1'b0;
    logic          resetn     = 1'b0;
    logic          I_start    = 1'b0;
    logic          I_abort    = 1'b0;
    logic [CW-1:0] I_batch_count = '0;
    logic          I_chain    = 1'b0;
    logic          I_trig_first_only = 1'b0;
    logic [TW-1:0] I_textin   = '0;
    logic [TW-1:0] O_cipherout;
    logic [CW-1:0] O_remaining;
    logic          O_busy, O_done, O_error, O_trigger;

    aes_batch_sequencer_if #(.pTEXT_WIDTH(TW)) core_if ();

    aes_batch_sequencer #(
        .pCNT_WIDTH  (CW),
        .pTIMEOUT    (TO),
        .pTEXT_WIDTH (TW)
    ) dut (
        .crypto_clk        (crypto_clk),
        .resetn            (resetn),
        .I_start           (I_start),
        .I_abort           (I_abort),
        .I_batch_count     (I_batch_count),
        .I_chain           (I_chain),
        .I_trig_first_only (I_trig_first_only),
        .I_textin          (I_textin),
        .core              (core_if),
        .O_cipherout       (O_cipherout),
        .O_remaining       (O_remaining),
        .O_busy            (O_busy),
        .O_done            (O_done),
        .O_error           (O_error),
        .O_trigger         (O_trigger)
    );

    always #5 crypto_clk = ~crypto_clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int trig_cycles = 0;

    always @(posedge crypto_clk) cyc++;

    task automatic check(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Stub cipher: the known AES-128 vector for PT0, otherwise a one-byte left rotation.
    function automatic logic [TW-1:0] core_f(input logic [TW-1:0] p);
        if (p == PT0) return CT0;
        return {p[TW-9:0], p[TW-1:TW-8]};
    endfunction

    // Batch-level expectations.
    logic [CW-1:0] m_rem = '0;
    logic [CW-1:0] m_count = '0;
    logic [TW-1:0] m_ct = '0;
    logic [TW-1:0] m_pt = '0;
    logic          m_done = 1'b0, m_err = 1'b0, m_chain = 1'b0, m_first_only = 1'b0;
    logic          m_active = 1'b0;
    int            m_loads = 0;
    logic          core_dead = 1'b0;

    task automatic model_complete(input logic [TW-1:0] p);
        if (m_active) begin
            m_ct = core_f(p);
            if (m_rem != '0) m_rem = m_rem - 1'b1;
            if (m_chain) m_pt = core_f(p);
            if (m_rem == '0) begin
                m_done   = 1'b1;
                m_active = 1'b0;
            end
        end
    endtask

    // Stub core: busy rises two cycles after load, stays high RUNLEN cycles.
    logic          core_act;
    int            core_cnt;
    logic [TW-1:0] core_pt;

    always @(posedge crypto_clk or negedge resetn) begin
        if (!resetn) begin
            core_if.I_aes_busy <= 1'b0;
            core_if.I_aes_ct   <= '0;
            core_act <= 1'b0;
            core_cnt <= 0;
            core_pt  <= '0;
        end else if (!core_act) begin
            if (core_if.O_aes_load && !core_dead) begin
                core_act <= 1'b1;
                core_cnt <= 0;
                core_pt  <= core_if.O_aes_pt;
            end
        end else begin
            core_cnt <= core_cnt + 1;
            if (core_cnt == 0) core_if.I_aes_busy <= 1'b1;
            if (core_cnt == RUNLEN) begin
                core_if.I_aes_busy <= 1'b0;
                core_if.I_aes_ct   <= core_f(core_pt);
                core_act <= 1'b0;
                model_complete(core_pt);
            end
        end
    end

    // Per-cycle compare against the model.
    logic pend = 1'b0, pend_exp = 1'b0, prev_idle = 1'b0;

    always @(negedge crypto_clk) begin
        if (!resetn) begin
            pend      = 1'b0;
            prev_idle = 1'b0;
        end else begin
            if (O_trigger) trig_cycles++;
            if (pend) begin
                check("trigger_window", {127'd0, O_trigger}, {127'd0, pend_exp});
                pend = 1'b0;
            end
            if (core_if.O_aes_load) begin
                check("load_allowed", {127'd0, O_busy && m_active && (m_loads < int'(m_count))}, 128'd1);
                check("load_pt", core_if.O_aes_pt, m_pt);
                pend_exp = !m_first_only || (m_loads == 0);
                pend     = 1'b1;
                m_loads++;
            end
            if (!O_busy) begin
                check("idle_remaining", {112'd0, O_remaining}, {112'd0, m_rem});
                check("idle_cipherout", O_cipherout, m_ct);
                check("idle_done", {127'd0, O_done}, {127'd0, m_done});
                check("idle_error", {127'd0, O_error}, {127'd0, m_err});
                if (prev_idle) check("idle_trigger", {127'd0, O_trigger}, 128'd0);
            end
            prev_idle = !O_busy;
        end
    end

    task automatic do_start(input logic [CW-1:0] cnt, input logic ch, input logic tfo,
                            input logic [TW-1:0] txt, input logic with_abort);
        @(posedge crypto_clk);
        #1;
        I_start = 1'b1;
        I_abort = with_abort;
        I_batch_count = cnt;
        I_chain = ch;
        I_trig_first_only = tfo;
        I_textin = txt;
        @(posedge crypto_clk);
        #1;
        I_start = 1'b0;
        I_abort = 1'b0;
        if (!with_abort) begin
            m_done = (cnt == '0);
            m_err  = 1'b0;
            m_rem  = cnt;
            m_count = cnt;
            m_pt   = txt;
            m_chain = ch;
            m_first_only = tfo;
            m_loads = 0;
            m_active = (cnt != '0);
            if (core_dead && cnt != '0) begin
                m_done = 1'b1;
                m_err  = 1'b1;
            end
        end
    endtask

    task automatic do_abort();
        @(posedge crypto_clk);
        #1;
        I_abort = 1'b1;
        @(posedge crypto_clk);
        #1;
        I_abort  = 1'b0;
        m_active = 1'b0;
        m_done   = 1'b0;
        m_err    = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        do begin
            @(negedge crypto_clk);
            n++;
        end while (O_busy && n < 500);
        check({tag, "_reaches_idle"}, {127'd0, O_busy}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, n;

        // Reset state
        #23;
        check("reset_busy", {127'd0, O_busy}, 128'd0);
        check("reset_load", {127'd0, core_if.O_aes_load}, 128'd0);
        check("reset_pt", core_if.O_aes_pt, 128'd0);
        check("reset_outputs", {O_cipherout[0], O_remaining, O_done, O_error, O_trigger}, 128'd0);
        #4 resetn = 1'b1;

        check("model_pin_f1", core_f(CT0), 128'hc4e0d86a7b0430d8cdb78070b4c55a69);

        // Single encryption
        do_start(16'd1, 1'b0, 1'b0, PT0, 1'b0);
        wait_idle("b1");
        check("b1_cipherout", O_cipherout, CT0);
        check("b1_done", {127'd0, O_done}, 128'd1);
        check("b1_remaining", {112'd0, O_remaining}, 128'd0);
        check("b1_loads", m_loads, 128'd1);

        // Chained batch of three with an ignored start in the middle
        do_start(16'd3, 1'b1, 1'b0, PT0, 1'b0);
        repeat (20) @(posedge crypto_clk);
        #1;
        I_start = 1'b1;
        I_batch_count = 16'd9;
        I_textin = '0;
        @(posedge crypto_clk);
        #1;
        I_start = 1'b0;
        wait_idle("b3");
        check("b3_cipherout", O_cipherout, 128'he0d86a7b0430d8cdb78070b4c55a69c4);
        check("b3_loads", m_loads, 128'd3);
        check("b3_remaining", {112'd0, O_remaining}, 128'd0);

        // Five runs, trigger on the first only: LOAD + 2 WAIT_BUSY + 10 RUN cycles
        trig_cycles = 0;
        do_start(16'd5, 1'b0, 1'b1, PT0, 1'b0);
        wait_idle("b5");
        check("b5_loads", m_loads, 128'd5);
        check("b5_trig_cycles", trig_cycles, 128'd13);
        check("b5_cipherout", O_cipherout, CT0);

        // Dead core: timeout
        core_dead = 1'b1;
        do_start(16'd1, 1'b0, 1'b0, PT1, 1'b0);
        n = 0;
        while (!core_if.O_aes_load && n < 50) begin
            @(negedge crypto_clk);
            n++;
        end
        c0 = cyc;
        n = 0;
        while (!O_error && n < 50) begin
            @(negedge crypto_clk);
            n++;
        end
        check("to_latency", cyc - c0, 128'd9);
        wait_idle("to");
        check("to_error", {127'd0, O_error}, 128'd1);
        check("to_done", {127'd0, O_done}, 128'd1);
        check("to_remaining", {112'd0, O_remaining}, 128'd1);
        core_dead = 1'b0;

        // Abort during the second run
        do_start(16'd4, 1'b0, 1'b0, PT1, 1'b0);
        n = 0;
        while (m_loads < 2 && n < 100) begin
            @(negedge crypto_clk);
            n++;
        end
        n = 0;
        while (!core_if.I_aes_busy && n < 20) begin
            @(negedge crypto_clk);
            n++;
        end
        do_abort();
        @(negedge crypto_clk);
        check("ab_busy", {127'd0, O_busy}, 128'd0);
        check("ab_remaining", {112'd0, O_remaining}, 128'd3);
        repeat (30) @(posedge crypto_clk);
        check("ab_loads", m_loads, 128'd2);

        // Zero count, then start+abort together
        do_start(16'd0, 1'b0, 1'b0, PT0, 1'b0);
        @(negedge crypto_clk);
        check("z_done", {127'd0, O_done}, 128'd1);
        check("z_busy", {127'd0, O_busy}, 128'd0);
        do_start(16'd3, 1'b0, 1'b0, PT0, 1'b1);
        @(negedge crypto_clk);
        check("sa_busy", {127'd0, O_busy}, 128'd0);
        check("sa_done", {127'd0, O_done}, 128'd1);
        repeat (5) @(posedge crypto_clk);

        // Restart after abort
        do_start(16'd2, 1'b0, 1'b0, PT0, 1'b0);
        wait_idle("b2");
        check("b2_cipherout", O_cipherout, CT0);
        check("b2_remaining", {112'd0, O_remaining}, 128'd0);
        check("b2_done", {127'd0, O_done}, 128'd1);

        // Asynchronous reset mid-batch
        do_start(16'd2, 1'b1, 1'b0, PT1, 1'b0);
        n = 0;
        while (!core_if.I_aes_busy && n < 20) begin
            @(negedge crypto_clk);
            n++;
        end
        #2 resetn = 1'b0;
        #1;
        check("ar_busy", {127'd0, O_busy}, 128'd0);
        check("ar_outputs", {O_cipherout[TW-1:TW-8], O_remaining, O_done, O_error, O_trigger}, 128'd0);
        check("ar_pt", core_if.O_aes_pt, 128'd0);
        m_rem = '0; m_ct = '0; m_pt = '0; m_done = 1'b0; m_err = 1'b0; m_active = 1'b0;
        repeat (3) @(posedge crypto_clk);
        #2 resetn = 1'b1;
        repeat (20) @(posedge crypto_clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
